data_c_intc_m2s_wrr: RTL and testbench
======================================

DATA_C_INTC_M2S_WRR -- requirements
Module: data_c_intc_m2s_wrr

Interface
REQ-001 Parameter NUM, default 8: number of slave channels; legal range 2..16.
REQ-002 Parameter DSIZE, default 8: payload width per channel in bits.
REQ-003 Parameter WSIZE, default 4: width of each per-channel weight in bits.
REQ-004 Parameter MODE, default "WRR": "WRR" uses the weights; "RR" treats every weight as 1.
REQ-005 Port clock, input, 1: single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port weight, input, NUM*WSIZE: packets per turn for channel k at bits [k*WSIZE +: WSIZE]; 0 disables channel k.
REQ-008 Port s_valid, input, NUM: per-channel beat valid.
REQ-009 Port s_data, input, NUM*DSIZE: per-channel payload; channel k at [k*DSIZE +: DSIZE].
REQ-010 Port s_last, input, NUM: per-channel end-of-packet marker.
REQ-011 Port s_ready, output, NUM: per-channel ready; one-hot or zero.
REQ-012 Port m_valid, output, 1: master beat valid.
REQ-013 Port m_data, output, DSIZE: master payload.
REQ-014 Port m_last, output, 1: master end-of-packet.
REQ-015 Port m_chn, output, clog2(NUM): source channel of the current m beat.
REQ-016 Port m_ready, input, 1: master ready.

Function
REQ-017 The arbitration FSM SHALL have two states: IDLE (no grant) and LOCK (grant held for one packet).
REQ-018 In IDLE, a channel is eligible when s_valid[k]=1 and its effective weight is non-zero.
REQ-019 In IDLE, the block SHALL search cyclically from pointer ptr and grant the first eligible channel.
REQ-020 The grant SHALL be registered, and the FSM SHALL enter LOCK on the next edge; s_ready stays 0 during the IDLE cycle.
REQ-021 Each packet therefore incurs exactly one bubble cycle.
REQ-022 On granting a channel other than the holder of the current credit, the block SHALL set ptr to that channel and load credit from weight[k], sampled at that edge.
REQ-023 In LOCK, s_ready[grant] SHALL equal (!m_valid || m_ready); all other s_ready bits SHALL be 0.
REQ-024 The output stage SHALL be one register: an s handshake loads m_data, m_last and m_chn and sets m_valid on the next edge.
REQ-025 The output register SHALL clear m_valid on an m handshake that has no simultaneous load.
REQ-026 Throughput SHALL be one beat per cycle while locked with m_ready=1.
REQ-027 While m_valid=1 and m_ready=0, m_data, m_last and m_chn SHALL hold stable and no s beat is accepted.
REQ-028 An s handshake with s_last=1 SHALL decrement credit and return the FSM to IDLE on the next edge.
REQ-029 In the next IDLE cycle, if credit>0 and s_valid[ptr]=1, ptr SHALL be re-granted without a credit reload.
REQ-030 Otherwise, in that IDLE cycle, the remaining credit SHALL be forfeited and the search SHALL start at ptr+1, wrapping at NUM-1 to 0.
REQ-031 Mid-packet gaps (s_valid[grant]=0 while in LOCK) SHALL hold the grant indefinitely; no timeout.
REQ-032 Packets from different channels SHALL never interleave on m.
REQ-033 A weight change while a credit is active SHALL take effect only at the next credit load.
REQ-034 Credit arithmetic SHALL be unsigned WSIZE bits and never underflow below 0.
REQ-035 If no channel is eligible, the block SHALL remain in IDLE with s_ready=0.

Reset
REQ-036 On an edge with rst=1, the block SHALL set state=IDLE, ptr=0, credit=0, m_valid=0, m_last=0, m_data=0, m_chn=0 and s_ready=0.
REQ-037 A reset asserted mid-packet SHALL truncate the packet, drop any beat held in the output register, and apply no recovery.
REQ-038 After rst deasserts, the first grant search SHALL start at channel 0.

Verification
REQ-039 Scenario MODE="RR", NUM=8, all channels always valid with 3-beat packets, m_ready=1 -> m_chn packet sequence is 0,1,...,7,0 and each packet is followed by exactly one bubble.
REQ-040 Scenario MODE="WRR", weights {ch0=3, ch1=1, others=0}, ch0 and ch1 continuously valid -> packet order is 0,0,0,1,0,0,0,1.
REQ-041 Scenario ch2 granted, beat 2 of 4 stalled by m_ready=0 for 5 cycles -> m_data stays equal to beat 2 and s_ready[2]=0 throughout; no beat is lost or duplicated.
REQ-042 Scenario ch1 weight=2 sends one packet and then drops s_valid while ch5 is valid -> the next grant goes to ch5 and ch1's credit is forfeited.
REQ-043 Scenario rst=1 for one cycle during beat 3 of a ch4 packet -> the next edge shows m_valid=0, s_ready=0 and ptr=0, and a later request on ch0 and ch4 grants ch0 first.
REQ-044 Scenario all weights 0 with all s_valid=1 -> s_ready stays 0 and m_valid stays 0 indefinitely.

Source files
------------

// File: rtl/data_c_intc_m2s_wrr.sv
// ---------------------------------------------------------------------------
// data_c_intc_m2s_wrr
//   Packet-level weighted round-robin arbiter: NUM slave channels feed one
//   master channel. A grant is held for a whole packet (until s_last), and a
//   channel may take up to weight[k] packets per turn before the search moves
//   on to the next channel.
//
// Handshake rule (both sides): a beat transfers on a rising edge where
//   valid && ready. The master side holds m_data/m_last/m_chn stable while
//   m_valid=1 and m_ready=0.
//
// Ports
//   clock      : rising-edge clock
//   rst        : synchronous active-high reset
//   weight     : packets per turn, channel k at [k*WSIZE +: WSIZE]; 0 disables
//   s_valid    : per-channel beat valid
//   s_data     : per-channel payload, channel k at [k*DSIZE +: DSIZE]
//   s_last     : per-channel end-of-packet
//   s_ready    : per-channel ready, one-hot or zero
//   m_valid    : master beat valid
//   m_data     : master payload
//   m_last     : master end-of-packet
//   m_chn      : source channel of the current master beat
//   m_ready    : master ready
//   dbg_lock   : arbitration FSM state (0 = IDLE, 1 = LOCK)
//   dbg_ptr    : current round-robin pointer / credit holder
//   dbg_credit : remaining packets for the credit holder
// ---------------------------------------------------------------------------
module data_c_intc_m2s_wrr #(
  parameter int    NUM   = 8,
  parameter int    DSIZE = 8,
  parameter int    WSIZE = 4,
  parameter string MODE  = "WRR",
  localparam int   PW    = $clog2(NUM)
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NUM*WSIZE-1:0]   weight,
  input  logic [NUM-1:0]         s_valid,
  input  logic [NUM*DSIZE-1:0]   s_data,
  input  logic [NUM-1:0]         s_last,
  output logic [NUM-1:0]         s_ready,
  output logic                   m_valid,
  output logic [DSIZE-1:0]       m_data,
  output logic                   m_last,
  output logic [PW-1:0]          m_chn,
  input  logic                   m_ready,
  output logic                   dbg_lock,
  output logic [PW-1:0]          dbg_ptr,
  output logic [WSIZE-1:0]       dbg_credit
);

  localparam bit RR_MODE = (MODE == "RR");

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, grant, pick, start;
  logic [WSIZE-1:0]  credit;
  logic              fresh;     // set by reset: first search starts at ptr, not ptr+1
  logic              found, regrant, load;
  logic [NUM-1:0]    eligible;
  logic [WSIZE-1:0]  eff_w [NUM];
  logic [DSIZE-1:0]  sel_data;
  logic              sel_valid, sel_last;

  // Effective weights and eligibility
  always_comb begin
    for (int k = 0; k < NUM; k++) begin
      eff_w[k]    = RR_MODE ? WSIZE'(1) : weight[k*WSIZE +: WSIZE];
      eligible[k] = s_valid[k] && (eff_w[k] != '0);
    end
  end

  // Cyclic search for the first eligible channel starting at 'start'
  always_comb begin : search
    int idx;
    if (fresh)                       start = ptr;
    else if (ptr == PW'(NUM - 1))    start = '0;
    else                             start = ptr + 1'b1;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM; i++) begin
      idx = (int'(start) + i) % NUM;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  // The credit holder keeps its turn only if it is requesting right now
  assign regrant = (credit != '0) && s_valid[ptr];

  // Granted channel's slave signals
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM; k++) begin
      if (grant == PW'(k)) begin
        sel_valid = s_valid[k];
        sel_last  = s_last[k];
        sel_data  = s_data[k*DSIZE +: DSIZE];
      end
    end
  end

  // Next state and slave-ready decode
  always_comb begin
    state_nxt = state;
    s_ready   = '0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (regrant || found) state_nxt = LOCK;
      end
      LOCK: begin
        for (int k = 0; k < NUM; k++) begin
          if (grant == PW'(k)) s_ready[k] = !m_valid || m_ready;
        end
        load = sel_valid && (!m_valid || m_ready);
        if (load && sel_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      grant   <= '0;
      credit  <= '0;
      fresh   <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_chn   <= '0;
    end else begin
      state <= state_nxt;

      if (state == IDLE) begin
        if (regrant) begin
          grant <= ptr;
        end else if (found) begin
          grant  <= pick;
          ptr    <= pick;
          credit <= eff_w[pick];
          fresh  <= 1'b0;
        end else begin
          credit <= '0;   // holder not requesting: its remaining turn is lost
        end
      end

      if (load && sel_last && (credit != '0)) credit <= credit - 1'b1;

      if (load) begin
        m_valid <= 1'b1;
        m_data  <= sel_data;
        m_last  <= sel_last;
        m_chn   <= grant;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  assign dbg_lock   = (state == LOCK);
  assign dbg_ptr    = ptr;
  assign dbg_credit = credit;

endmodule

// File: tb/tb_data_c_intc_m2s_wrr.sv
// ---------------------------------------------------------------------------
// tb_data_c_intc_m2s_wrr
//   Directed bench for the packet WRR arbiter. Two instances share stimulus:
//   one with MODE="WRR" and one with MODE="RR". Per-channel packet sources
//   emit data {channel, per-channel beat count}; a monitor logs every master
//   handshake of the selected instance.
// ---------------------------------------------------------------------------
module tb_data_c_intc_m2s_wrr;
  localparam int NUM = 8, DSIZE = 8, WSIZE = 4, PW = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 rst = 1'b1;
  logic [NUM*WSIZE-1:0] weight = '0;
  logic [NUM-1:0]       s_valid = '0, s_last = '0;
  logic [NUM*DSIZE-1:0] s_data = '0;
  logic                 m_ready = 1'b1;

  logic [NUM-1:0]   s_ready_w, s_ready_r;
  logic             m_valid_w, m_valid_r, m_last_w, m_last_r, dbg_lock_w, dbg_lock_r;
  logic [DSIZE-1:0] m_data_w, m_data_r;
  logic [PW-1:0]    m_chn_w, m_chn_r, dbg_ptr_w, dbg_ptr_r;
  logic [WSIZE-1:0] dbg_credit_w, dbg_credit_r;

  data_c_intc_m2s_wrr #(.NUM(NUM), .DSIZE(DSIZE), .WSIZE(WSIZE), .MODE("WRR")) dut (
    .clock(clock), .rst(rst), .weight(weight), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready_w), .m_valid(m_valid_w), .m_data(m_data_w),
    .m_last(m_last_w), .m_chn(m_chn_w), .m_ready(m_ready), .dbg_lock(dbg_lock_w),
    .dbg_ptr(dbg_ptr_w), .dbg_credit(dbg_credit_w));

  data_c_intc_m2s_wrr #(.NUM(NUM), .DSIZE(DSIZE), .WSIZE(WSIZE), .MODE("RR")) dut_rr (
    .clock(clock), .rst(rst), .weight(weight), .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_ready(s_ready_r), .m_valid(m_valid_r), .m_data(m_data_r),
    .m_last(m_last_r), .m_chn(m_chn_r), .m_ready(m_ready), .dbg_lock(dbg_lock_r),
    .dbg_ptr(dbg_ptr_r), .dbg_credit(dbg_credit_r));

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;

  // ---------------- packet sources ----------------
  int beat [NUM], pkts [NUM], sent [NUM], len [NUM], max_pkts [NUM];
  bit en [NUM];
  bit sel_rr = 1'b0;
  logic [NUM-1:0] hs;

  task automatic refresh_src();
    for (int k = 0; k < NUM; k++) begin
      s_valid[k] = en[k] && (max_pkts[k] == 0 || pkts[k] < max_pkts[k]);
      s_data[k*DSIZE +: DSIZE] = 8'((k * 16) + (sent[k] % 16));
      s_last[k] = (beat[k] == len[k] - 1);
    end
  endtask

  task automatic clear_src();
    for (int k = 0; k < NUM; k++) begin
      beat[k] = 0; pkts[k] = 0; sent[k] = 0; len[k] = 1; max_pkts[k] = 0; en[k] = 1'b0;
    end
    refresh_src();
  endtask

  always @(posedge clock) begin
    hs = rst ? '0 : (s_valid & (sel_rr ? s_ready_r : s_ready_w));
    #1;
    for (int k = 0; k < NUM; k++) begin
      if (hs[k]) begin
        sent[k]++;
        if (beat[k] == len[k] - 1) begin
          beat[k] = 0;
          pkts[k]++;
        end else begin
          beat[k]++;
        end
      end
    end
    refresh_src();
  end

  // ---------------- master monitor ----------------
  bit            mon_on = 1'b0;
  logic [PW-1:0] log_chn [$];
  logic [7:0]    log_data [$];
  logic          log_last [$];
  int            log_cyc [$];
  logic [PW-1:0] pkt_chn [$];
  int            pkt_cyc [$];

  always @(negedge clock) begin
    if (mon_on) begin
      if (sel_rr ? (m_valid_r && m_ready) : (m_valid_w && m_ready)) begin
        log_chn.push_back(sel_rr ? m_chn_r : m_chn_w);
        log_data.push_back(sel_rr ? m_data_r : m_data_w);
        log_last.push_back(sel_rr ? m_last_r : m_last_w);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_log();
    log_chn.delete(); log_data.delete(); log_last.delete(); log_cyc.delete();
  endtask

  task automatic build_packets();
    pkt_chn.delete(); pkt_cyc.delete();
    for (int i = 0; i < log_chn.size(); i++) begin
      if (i == 0 || log_last[i-1]) begin
        pkt_chn.push_back(log_chn[i]);
        pkt_cyc.push_back(log_cyc[i]);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Two reset edges; returns 1ns after the last one with rst released.
  task automatic do_reset();
    mon_on = 1'b0;
    rst = 1'b1;
    m_ready = 1'b1;
    tick(1);
    clear_src();
    clear_log();
    tick(1);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (m_valid_w !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %0b expected 0", m_valid_w); end
    n_cmp++; if (s_ready_w !== '0) begin n_fail++; $display("FAIL reset_s_ready: got %0h expected 0", s_ready_w); end
    n_cmp++; if (m_data_w !== '0) begin n_fail++; $display("FAIL reset_m_data: got %0h expected 0", m_data_w); end
    n_cmp++; if (m_last_w !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %0b expected 0", m_last_w); end
    n_cmp++; if (m_chn_w !== '0) begin n_fail++; $display("FAIL reset_m_chn: got %0d expected 0", m_chn_w); end
    n_cmp++; if (dbg_lock_w !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %0b expected 0", dbg_lock_w); end
    n_cmp++; if (dbg_ptr_w !== '0) begin n_fail++; $display("FAIL reset_ptr: got %0d expected 0", dbg_ptr_w); end
    n_cmp++; if (dbg_credit_w !== '0) begin n_fail++; $display("FAIL reset_credit: got %0d expected 0", dbg_credit_w); end
    n_cmp++; if (m_valid_r !== 1'b0) begin n_fail++; $display("FAIL reset_rr_m_valid: got %0b expected 0", m_valid_r); end
  endtask

  // RR mode, all channels valid, 3-beat packets, weights all 0 (ignored in RR)
  task automatic test_back_to_back();
    int seq [NUM];
    logic [7:0] exp_d;
    do_reset();
    sel_rr = 1'b1;
    weight = '0;
    for (int k = 0; k < NUM; k++) begin en[k] = 1'b1; len[k] = 3; seq[k] = 0; end
    refresh_src();
    mon_on = 1'b1;
    tick(40);
    mon_on = 1'b0;
    build_packets();
    n_cmp++; if (pkt_chn.size() < 10) begin n_fail++; $display("FAIL rr_pkt_count: got %0d expected >=10", pkt_chn.size()); end
    for (int n = 0; n < 9 && n < pkt_chn.size(); n++) begin
      n_cmp++;
      if (pkt_chn[n] !== 3'(n % 8)) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", n, pkt_chn[n], n % 8); end
    end
    for (int n = 0; n < 9 && n + 1 < pkt_cyc.size(); n++) begin
      n_cmp++;
      if (pkt_cyc[n+1] - pkt_cyc[n] !== 4) begin n_fail++; $display("FAIL rr_bubble[%0d]: got spacing %0d expected 4", n, pkt_cyc[n+1] - pkt_cyc[n]); end
    end
    for (int i = 0; i < log_chn.size(); i++) begin
      exp_d = 8'((int'(log_chn[i]) * 16) + (seq[log_chn[i]] % 16));
      seq[log_chn[i]]++;
      n_cmp++;
      if (log_data[i] !== exp_d || log_last[i] !== (i % 3 == 2)) begin
        n_fail++; $display("FAIL rr_beat[%0d]: got data %0h last %0b expected data %0h last %0b", i, log_data[i], log_last[i], exp_d, (i % 3 == 2));
      end
    end
    sel_rr = 1'b0;
  endtask

  task automatic test_wrr();
    int exp_seq [8];
    exp_seq = '{0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    weight = 32'h0000_0013;   // ch0=3, ch1=1, others 0
    for (int k = 0; k < NUM; k++) begin en[k] = 1'b1; len[k] = 2; end
    refresh_src();
    mon_on = 1'b1;
    tick(36);
    mon_on = 1'b0;
    build_packets();
    n_cmp++; if (pkt_chn.size() < 8) begin n_fail++; $display("FAIL wrr_pkt_count: got %0d expected >=8", pkt_chn.size()); end
    for (int n = 0; n < 8 && n < pkt_chn.size(); n++) begin
      n_cmp++;
      if (pkt_chn[n] !== 3'(exp_seq[n])) begin n_fail++; $display("FAIL wrr_order[%0d]: got %0d expected %0d", n, pkt_chn[n], exp_seq[n]); end
    end
  endtask

  task automatic test_stall();
    bit seen;
    do_reset();
    weight = 32'h0000_0100;   // ch2=1
    en[2] = 1'b1; len[2] = 4; max_pkts[2] = 1;
    refresh_src();
    mon_on = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (m_valid_w && m_data_w == 8'h21) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL stall_beat2_timeout: got none expected m_data 21"); end
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_cmp++;
      if (m_valid_w !== 1'b1 || m_data_w !== 8'h21 || m_chn_w !== 3'd2 || s_ready_w[2] !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v %0b d %0h c %0d rdy %0b expected v 1 d 21 c 2 rdy 0", i, m_valid_w, m_data_w, m_chn_w, s_ready_w[2]);
      end
    end
    m_ready = 1'b1;
    tick(8);
    mon_on = 1'b0;
    n_cmp++; if (log_data.size() !== 4) begin n_fail++; $display("FAIL stall_beat_count: got %0d expected 4", log_data.size()); end
    for (int i = 0; i < 4 && i < log_data.size(); i++) begin
      n_cmp++;
      if (log_data[i] !== 8'(8'h20 + i) || log_last[i] !== (i == 3)) begin
        n_fail++; $display("FAIL stall_beat[%0d]: got %0h/%0b expected %0h/%0b", i, log_data[i], log_last[i], 8'h20 + i, (i == 3));
      end
    end
  endtask

  task automatic test_forfeit();
    do_reset();
    weight = 32'h0030_0020;   // ch1=2, ch5=3
    en[1] = 1'b1; len[1] = 2; max_pkts[1] = 1;
    en[5] = 1'b1; len[5] = 2; max_pkts[5] = 1;
    refresh_src();
    mon_on = 1'b1;
    tick(3);   // grant ch1, two beats; ch1 keeps 1 credit
    n_cmp++; if (dbg_lock_w !== 1'b0 || dbg_credit_w !== 4'd1) begin n_fail++; $display("FAIL forfeit_after_ch1: got lock %0b credit %0d expected lock 0 credit 1", dbg_lock_w, dbg_credit_w); end
    tick(1);   // ch1 idle: credit dropped, ch5 granted with weight 3
    n_cmp++; if (dbg_lock_w !== 1'b1 || dbg_ptr_w !== 3'd5 || dbg_credit_w !== 4'd3) begin n_fail++; $display("FAIL forfeit_grant_ch5: got lock %0b ptr %0d credit %0d expected 1 5 3", dbg_lock_w, dbg_ptr_w, dbg_credit_w); end
    tick(16);
    mon_on = 1'b0;
    build_packets();
    n_cmp++; if (pkt_chn.size() !== 2) begin n_fail++; $display("FAIL forfeit_pkt_count: got %0d expected 2", pkt_chn.size()); end
    n_cmp++; if (pkt_chn.size() >= 2 && (pkt_chn[0] !== 3'd1 || pkt_chn[1] !== 3'd5)) begin n_fail++; $display("FAIL forfeit_order: got %0d,%0d expected 1,5", pkt_chn[0], pkt_chn[1]); end
    n_cmp++; if (dbg_credit_w !== 4'd0 || dbg_ptr_w !== 3'd5) begin n_fail++; $display("FAIL forfeit_final: got credit %0d ptr %0d expected 0 5", dbg_credit_w, dbg_ptr_w); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    weight = 32'h0001_0001;   // ch0=1, ch4=1
    en[4] = 1'b1; len[4] = 6;
    refresh_src();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (m_valid_w && m_data_w == 8'h42) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL rstmid_beat3_timeout: got none expected m_data 42"); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_cmp++; if (m_valid_w !== 1'b0 || s_ready_w !== '0 || dbg_ptr_w !== '0 || dbg_lock_w !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_state: got v %0b rdy %0h ptr %0d lock %0b expected 0 0 0 0", m_valid_w, s_ready_w, dbg_ptr_w, dbg_lock_w);
    end
    clear_src();
    clear_log();
    en[0] = 1'b1; len[0] = 2; max_pkts[0] = 1;
    en[4] = 1'b1; len[4] = 2; max_pkts[4] = 1;
    refresh_src();
    mon_on = 1'b1;
    tick(15);
    mon_on = 1'b0;
    build_packets();
    n_cmp++; if (pkt_chn.size() !== 2) begin n_fail++; $display("FAIL rstmid_pkt_count: got %0d expected 2", pkt_chn.size()); end
    n_cmp++; if (pkt_chn.size() >= 2 && (pkt_chn[0] !== 3'd0 || pkt_chn[1] !== 3'd4)) begin n_fail++; $display("FAIL rstmid_order: got %0d,%0d expected 0,4", pkt_chn[0], pkt_chn[1]); end
    n_cmp++; if (log_data.size() >= 1 && log_data[0] !== 8'h00) begin n_fail++; $display("FAIL rstmid_first_data: got %0h expected 00", log_data[0]); end
  endtask

  task automatic test_all_zero();
    do_reset();
    weight = '0;
    for (int k = 0; k < NUM; k++) begin en[k] = 1'b1; len[k] = 2; end
    refresh_src();
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n_cmp++;
      if (s_ready_w !== '0 || m_valid_w !== 1'b0) begin
        n_fail++; $display("FAIL zero_weight[%0d]: got rdy %0h v %0b expected 0 0", i, s_ready_w, m_valid_w);
      end
    end
  endtask

  initial begin
    clear_src();
    test_reset();
    test_back_to_back();
    test_wrr();
    test_stall();
    test_forfeit();
    test_reset_mid();
    test_all_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
